request_dispatcher: RTL and testbench

//  Command front-end directly upstream of SensorDecoder. Assembles 2-byte request frames from the

---
 rtl/request_dispatcher_pkg.sv | 30 +++
 rtl/frame_timer.sv | 25 ++
 rtl/request_dispatcher.sv | 208 ++++++++++++++++++++
 tb/tb_request_dispatcher.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/request_dispatcher_pkg.sv
// Shared state encoding, request/response codes and request-class helpers
// for the sensor command dispatcher.
package request_dispatcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ADDR,
    ST_DISPATCH,
    ST_WAIT_RESP,
    ST_MONITOR,
    ST_SEND_CODE,
    ST_SEND_DATA
  } state_e;

  localparam logic [7:0] REQ_MON_A     = 8'h03;
  localparam logic [7:0] REQ_MON_B     = 8'h04;
  localparam logic [7:0] REQ_UPD_A     = 8'h05;
  localparam logic [7:0] REQ_UPD_B     = 8'h06;
  localparam logic [7:0] CODE_BAD_ADDR = 8'hED;
  localparam logic [7:0] CODE_TIMEOUT  = 8'hEE;

  function automatic logic is_mon_start(input logic [7:0] r);
    return (r == REQ_MON_A) || (r == REQ_MON_B);
  endfunction

  function automatic logic is_mon_update(input logic [7:0] r);
    return (r == REQ_UPD_A) || (r == REQ_UPD_B);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating cycle counter: counts while enabled, flags expiry once it
// reaches LIMIT, and holds there until cleared.
module frame_timer #(
  parameter int unsigned LIMIT = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign expired = (count >= W'(LIMIT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/request_dispatcher.sv
// UART-side command front-end for the sensor decoder: assembles 2-byte request
// frames, drives the decoder, and returns a 2-byte code/response frame.
module request_dispatcher
  import request_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_DEVICES        = 32,
  parameter int unsigned INTER_BYTE_TIMEOUT = 50_000_000,
  parameter int unsigned RESPONSE_TIMEOUT   = 150_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dec_enable,
  output logic [7:0]  dec_request,
  output logic [31:0] dec_device_selector,
  input  logic [7:0]  dec_response,
  input  logic [7:0]  dec_response_code,
  input  logic        dec_finished,
  output logic        busy,
  output logic        rx_overrun
);

  state_e      state, state_nx;
  logic [7:0]  req_q, mon_req_q, code_q, resp_q;
  logic        monitor_q, mon_pend_q, fin_q;
  logic        ib_clear, ib_en, ib_exp, rt_clear, rt_en, rt_exp;
  logic        fin_edge, addr_ok, mon_rx;
  logic        take_b0, take_addr, bad_addr, mon_b0, mon_b1, mon_abort;
  logic        capture, timeout_err, drop, to_idle;
  logic [31:0] onehot;

  assign fin_edge = dec_finished & ~fin_q;
  assign addr_ok  = (32'(rx_data) < NUM_DEVICES);
  assign onehot   = 32'(1) << rx_data[4:0];
  assign busy     = (state != ST_IDLE);
  assign tx_valid = (state == ST_SEND_CODE) || (state == ST_SEND_DATA);
  assign tx_data  = (state == ST_SEND_CODE) ? code_q :
                    (state == ST_SEND_DATA) ? resp_q : 8'h00;

  frame_timer #(.LIMIT(INTER_BYTE_TIMEOUT)) u_ib_timer (
    .clock(clock), .reset_n(reset_n), .clear(ib_clear), .enable(ib_en), .expired(ib_exp)
  );

  frame_timer #(.LIMIT(RESPONSE_TIMEOUT)) u_rt_timer (
    .clock(clock), .reset_n(reset_n), .clear(rt_clear), .enable(rt_en), .expired(rt_exp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    take_b0     = 1'b0;
    take_addr   = 1'b0;
    bad_addr    = 1'b0;
    mon_b0      = 1'b0;
    mon_b1      = 1'b0;
    mon_abort   = 1'b0;
    capture     = 1'b0;
    timeout_err = 1'b0;
    to_idle     = 1'b0;
    ib_clear    = 1'b0;
    ib_en       = 1'b0;
    rt_clear    = 1'b0;
    rt_en       = 1'b0;
    mon_rx      = (state == ST_MONITOR) || (state == ST_WAIT_RESP && monitor_q);

    case (state)
      ST_IDLE: if (rx_valid) begin
        take_b0  = 1'b1;
        ib_clear = 1'b1;
        state_nx = ST_WAIT_ADDR;
      end
      ST_WAIT_ADDR: begin
        ib_en = 1'b1;
        if (rx_valid) begin
          if (addr_ok) begin
            take_addr = 1'b1;
            state_nx  = ST_DISPATCH;
          end else begin
            bad_addr = 1'b1;
            state_nx = ST_SEND_CODE;
          end
        end else if (ib_exp) begin
          state_nx = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        rt_clear = 1'b1;
        state_nx = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        rt_en = ~monitor_q;
        if (fin_edge) begin
          capture  = 1'b1;
          state_nx = ST_SEND_CODE;
        end else if (!monitor_q && rt_exp) begin
          timeout_err = 1'b1;
          state_nx    = ST_SEND_CODE;
        end
      end
      ST_MONITOR: if (fin_edge) begin
        capture  = 1'b1;
        state_nx = ST_SEND_CODE;
      end
      ST_SEND_CODE: if (tx_ready) state_nx = ST_SEND_DATA;
      ST_SEND_DATA: if (tx_ready) begin
        if (monitor_q && !is_mon_update(dec_request)) begin
          state_nx = ST_MONITOR;
        end else begin
          to_idle  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Monitor-mode frames run alongside the response wait; a completion edge
    // takes priority over any byte arriving in the same cycle.
    if (mon_rx) begin
      ib_en = mon_pend_q;
      if (rx_valid && !fin_edge) begin
        if (!mon_pend_q) begin
          mon_b0   = 1'b1;
          ib_clear = 1'b1;
        end else begin
          mon_b1 = 1'b1;
        end
      end else if (mon_pend_q && ib_exp) begin
        mon_abort = 1'b1;
      end
    end
  end

  assign drop = rx_valid && !(state == ST_IDLE || state == ST_WAIT_ADDR ||
                              (mon_rx && !fin_edge));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fin_q               <= 1'b0;
      req_q               <= '0;
      mon_req_q           <= '0;
      code_q              <= '0;
      resp_q              <= '0;
      monitor_q           <= 1'b0;
      mon_pend_q          <= 1'b0;
      dec_enable          <= 1'b0;
      dec_request         <= '0;
      dec_device_selector <= '0;
      rx_overrun          <= 1'b0;
    end else begin
      fin_q <= dec_finished;
      if (take_b0) begin
        req_q      <= rx_data;
        rx_overrun <= 1'b0;
      end
      if (mon_b0) begin
        mon_req_q  <= rx_data;
        mon_pend_q <= 1'b1;
        rx_overrun <= 1'b0;
      end
      if (mon_b1) begin
        mon_pend_q <= 1'b0;
        if (is_mon_update(mon_req_q) && addr_ok) begin
          dec_request         <= mon_req_q;
          dec_device_selector <= onehot;
        end
      end
      if (mon_abort) mon_pend_q <= 1'b0;
      if (take_addr) begin
        dec_request         <= req_q;
        dec_device_selector <= onehot;
      end
      if (bad_addr) begin
        code_q <= CODE_BAD_ADDR;
        resp_q <= CODE_BAD_ADDR;
      end
      if (state == ST_DISPATCH) begin
        dec_enable <= 1'b1;
        monitor_q  <= is_mon_start(req_q);
      end
      // In monitor mode the decoder stays enabled across reports.
      if (capture) begin
        code_q     <= dec_response_code;
        resp_q     <= dec_response;
        mon_pend_q <= 1'b0;
        if (!monitor_q) dec_enable <= 1'b0;
      end
      if (timeout_err) begin
        code_q     <= CODE_TIMEOUT;
        resp_q     <= CODE_TIMEOUT;
        dec_enable <= 1'b0;
      end
      if (to_idle) begin
        monitor_q  <= 1'b0;
        dec_enable <= 1'b0;
      end
      if (drop) rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_request_dispatcher.sv
// Scenario bench for request_dispatcher: directed frames plus randomized
// request/address/response traffic checked against frame-level expectations.
module tb_request_dispatcher;

  localparam int unsigned N  = 5;
  localparam int unsigned IB = 20;
  localparam int unsigned RT = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dec_enable;
  logic [7:0]  dec_request;
  logic [31:0] dec_device_selector;
  logic [7:0]  dec_response = '0;
  logic [7:0]  dec_response_code = '0;
  logic        dec_finished = 1'b0;
  logic        busy;
  logic        rx_overrun;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  logic en_seen = 1'b0;
  logic [7:0] txq[$];

  request_dispatcher #(.NUM_DEVICES(N), .INTER_BYTE_TIMEOUT(IB), .RESPONSE_TIMEOUT(RT)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dec_enable(dec_enable), .dec_request(dec_request),
    .dec_device_selector(dec_device_selector), .dec_response(dec_response),
    .dec_response_code(dec_response_code), .dec_finished(dec_finished),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clock = ~clock;

  initial tx_ready = 1'b1;
  always @(negedge clock) begin
    if (rdy_mode == 0)      tx_ready = 1'b1;
    else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else                    tx_ready = 1'b0;
  end

  always @(posedge clock)
    if (reset_n && tx_valid && tx_ready) txq.push_back(tx_data);

  always @(negedge clock)
    if (dec_enable) en_seen = 1'b1;

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_finished(input logic [7:0] code, input logic [7:0] resp);
    dec_response_code = code; dec_response = resp; dec_finished = 1'b1;
    @(negedge clock);
    dec_finished = 1'b0;
  endtask

  task automatic get_tx(output logic ok, output logic [7:0] b0, output logic [7:0] b1);
    for (int i = 0; i < 400 && txq.size() < 2; i++) @(negedge clock);
    ok = (txq.size() >= 2);
    b0 = 8'h00; b1 = 8'h00;
    if (ok) begin
      b0 = txq.pop_front();
      b1 = txq.pop_front();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_tx busy=%b tx_valid=%b tx_data=%h exp 0/0/00", busy, tx_valid, tx_data); end
    total++; if (dec_enable !== 1'b0 || dec_request !== 8'h00 || dec_device_selector !== 32'h0 || rx_overrun !== 1'b0) begin
      bad++; $display("FAIL reset_dec en=%b req=%h sel=%h ovr=%b exp all 0", dec_enable, dec_request, dec_device_selector, rx_overrun); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    logic ok; logic [7:0] b0, b1;
    send_byte(8'h01); send_byte(8'h00);
    total++; if (dec_device_selector !== 32'h1 || dec_request !== 8'h01) begin
      bad++; $display("FAIL basic_sel sel=%h req=%h exp 00000001/01", dec_device_selector, dec_request); end
    repeat (2) @(negedge clock);
    total++; if (dec_enable !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_enable en=%b busy=%b exp 1/1", dec_enable, busy); end
    pulse_finished(8'h13, 8'h19);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'h13 || b1 !== 8'h19) begin
      bad++; $display("FAIL basic_tx ok=%b got=%h,%h exp 13,19", ok, b0, b1); end
    @(negedge clock);
    total++; if (busy !== 1'b0 || dec_enable !== 1'b0) begin
      bad++; $display("FAIL basic_idle busy=%b en=%b exp 0/0", busy, dec_enable); end
  endtask

  task automatic test_bad_addr;
    logic ok; logic [7:0] b0, b1;
    en_seen = 1'b0;
    send_byte(8'h02); send_byte(8'(N));
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'hED || b1 !== 8'hED) begin
      bad++; $display("FAIL badaddr_tx ok=%b got=%h,%h exp ED,ED", ok, b0, b1); end
    @(negedge clock);
    total++; if (en_seen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL badaddr_enable seen=%b busy=%b exp 0/0", en_seen, busy); end
    send_byte(8'h02); send_byte(8'(N - 1));
    total++; if (dec_device_selector !== (32'h1 << (N - 1))) begin
      bad++; $display("FAIL lastaddr_sel got=%h exp %h", dec_device_selector, 32'h1 << (N - 1)); end
    repeat (2) @(negedge clock);
    pulse_finished(8'h11, 8'h42);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'h11 || b1 !== 8'h42) begin
      bad++; $display("FAIL lastaddr_tx ok=%b got=%h,%h exp 11,42", ok, b0, b1); end
    @(negedge clock);
  endtask

  task automatic test_inter_byte_timeout;
    logic ok; logic [7:0] b0, b1;
    send_byte(8'h01);
    repeat (IB + 5) @(negedge clock);
    total++; if (busy !== 1'b0 || txq.size() != 0) begin
      bad++; $display("FAIL ibto_idle busy=%b txq=%0d exp 0/0", busy, txq.size()); end
    send_byte(8'h02); send_byte(8'h00);
    total++; if (dec_request !== 8'h02 || dec_device_selector !== 32'h1) begin
      bad++; $display("FAIL ibto_next req=%h sel=%h exp 02/00000001", dec_request, dec_device_selector); end
    repeat (2) @(negedge clock);
    pulse_finished(8'h12, 8'h34);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'h12 || b1 !== 8'h34) begin
      bad++; $display("FAIL ibto_tx ok=%b got=%h,%h exp 12,34", ok, b0, b1); end
    @(negedge clock);
  endtask

  task automatic test_resp_timeout;
    logic ok; logic [7:0] b0, b1;
    send_byte(8'h01); send_byte(8'h00);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'hEE || b1 !== 8'hEE) begin
      bad++; $display("FAIL rto_tx ok=%b got=%h,%h exp EE,EE", ok, b0, b1); end
    @(negedge clock);
    total++; if (dec_enable !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rto_idle en=%b busy=%b exp 0/0", dec_enable, busy); end
  endtask

  task automatic test_monitor;
    logic ok; logic [7:0] b0, b1;
    send_byte(8'h03); send_byte(8'h00);
    repeat (3) @(negedge clock);
    pulse_finished(8'h15, 8'hCA);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'h15 || b1 !== 8'hCA) begin
      bad++; $display("FAIL mon_tx1 ok=%b got=%h,%h exp 15,CA", ok, b0, b1); end
    @(negedge clock);
    total++; if (busy !== 1'b1 || dec_enable !== 1'b1) begin
      bad++; $display("FAIL mon_state busy=%b en=%b exp 1/1", busy, dec_enable); end
    send_byte(8'h07); send_byte(8'h01);
    total++; if (dec_request !== 8'h03 || dec_device_selector !== 32'h1) begin
      bad++; $display("FAIL mon_ignore req=%h sel=%h exp 03/00000001", dec_request, dec_device_selector); end
    send_byte(8'h05); send_byte(8'h02);
    total++; if (dec_request !== 8'h05 || dec_device_selector !== 32'h4) begin
      bad++; $display("FAIL mon_update req=%h sel=%h exp 05/00000004", dec_request, dec_device_selector); end
    pulse_finished(8'h17, 8'hCA);
    get_tx(ok, b0, b1);
    total++; if (!ok || b0 !== 8'h17 || b1 !== 8'hCA) begin
      bad++; $display("FAIL mon_tx2 ok=%b got=%h,%h exp 17,CA", ok, b0, b1); end
    @(negedge clock);
    total++; if (busy !== 1'b0 || dec_enable !== 1'b0) begin
      bad++; $display("FAIL mon_exit busy=%b en=%b exp 0/0", busy, dec_enable); end
  endtask

  task automatic test_overrun;
    logic ok; logic [7:0] b0, b1;
    send_byte(8'h01); send_byte(8'h01);
    send_byte(8'hAA);
    total++; if (rx_overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_set got=%b exp 1", rx_overrun); end
    pulse_finished(8'h10, 8'h20);
    get_tx(ok, b0, b1);
    @(negedge clock);
    total++; if (!ok || b0 !== 8'h10 || b1 !== 8'h20 || rx_overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_sticky ok=%b got=%h,%h ovr=%b exp 10,20 ovr=1", ok, b0, b1, rx_overrun); end
    send_byte(8'h02);
    total++; if (rx_overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_clear got=%b exp 0", rx_overrun); end
    send_byte(8'h00);
    repeat (2) @(negedge clock);
    pulse_finished(8'h16, 8'h01);
    get_tx(ok, b0, b1);
    @(negedge clock);
  endtask

  task automatic test_random;
    logic ok; logic [7:0] b0, b1, req, addr, code, resp, e0, e1;
    int gap;
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) begin
      req  = 8'($urandom_range(0, 255));
      if (req == 8'h03 || req == 8'h04) req = 8'h80;
      addr = 8'($urandom_range(0, 7));
      code = 8'($urandom); resp = 8'($urandom);
      gap  = $urandom_range(0, 10);
      en_seen = 1'b0;
      send_byte(req);
      repeat (gap) @(negedge clock);
      send_byte(addr);
      if (32'(addr) < N) begin
        total++; if (dec_device_selector !== (32'h1 << addr) || dec_request !== req) begin
          bad++; $display("FAIL rnd_sel[%0d] sel=%h req=%h exp %h/%h", i, dec_device_selector, dec_request, 32'h1 << addr, req); end
        repeat ($urandom_range(2, 10)) @(negedge clock);
        pulse_finished(code, resp);
        e0 = code; e1 = resp;
      end else begin
        e0 = 8'hED; e1 = 8'hED;
      end
      get_tx(ok, b0, b1);
      @(negedge clock);
      total++; if (!ok || b0 !== e0 || b1 !== e1 || busy !== 1'b0 || en_seen !== (32'(addr) < N)) begin
        bad++; $display("FAIL rnd_tx[%0d] ok=%b got=%h,%h busy=%b en=%b exp %h,%h", i, ok, b0, b1, busy, en_seen, e0, e1); end
    end
    rdy_mode = 0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_send;
    int stable_bad = 0;
    int wait_cyc = 0;
    rdy_mode = 2;
    @(negedge clock);
    send_byte(8'h01); send_byte(8'h00);
    repeat (2) @(negedge clock);
    pulse_finished(8'h21, 8'h22);
    while (!tx_valid && wait_cyc < 50) begin @(negedge clock); wait_cyc++; end
    total++; if (tx_valid !== 1'b1) begin
      bad++; $display("FAIL hold_valid got=%b exp 1", tx_valid); end
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h21) stable_bad++;
      @(negedge clock);
    end
    total++; if (stable_bad != 0) begin
      bad++; $display("FAIL hold_stable unstable_cycles=%0d exp 0", stable_bad); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL async_reset tx_valid=%b busy=%b exp 0/0", tx_valid, busy); end
    @(negedge clock);
    reset_n = 1'b1;
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    total++; if (txq.size() != 0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_tx txq=%0d tx_valid=%b exp 0/0", txq.size(), tx_valid); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_bad_addr();
    test_inter_byte_timeout();
    test_resp_timeout();
    test_monitor();
    test_overrun();
    test_random();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
